// File: rtl/sockit_spi_pkg.sv
// Shared types for the SPI master: command word layout, arbiter tag and
// arbiter state encoding.
package sockit_spi_pkg;

  typedef struct packed {
    logic        lst;
    logic        wr;
    logic        rd;
    logic [12:0] arg;
  } cmd_t;

  typedef logic arb_tag_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // Winner among requesting ports; with round-robin a tie goes to the port
  // that was not granted last.
  function automatic arb_tag_t arb_pick(input logic rr, input arb_tag_t last,
                                        input logic v0, input logic v1);
    if (v0 && v1) return rr ? arb_tag_t'(~last) : arb_tag_t'(1'b0);
    return v0 ? arb_tag_t'(1'b0) : arb_tag_t'(1'b1);
  endfunction

endpackage

// File: rtl/sockit_spi_arb_tfifo.sv
// Synchronous tag FIFO; records which port owns each outstanding data word.
module sockit_spi_arb_tfifo #(
  parameter int unsigned DEP = 4,
  parameter int unsigned TW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [TW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [TW-1:0] head
);

  localparam int unsigned AW = (DEP > 1) ? $clog2(DEP) : 1;
  localparam int unsigned CW = $clog2(DEP + 1);

  logic [TW-1:0] mem [DEP];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  // A pop frees its slot before the push in the same cycle claims one.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == CW'(DEP));
  assign empty   = (cnt == '0);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push != do_pop) cnt <= do_push ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/sockit_spi_arb.sv
// Two-port arbiter in front of the CDC stage: holds grants for whole SPI
// transactions and routes write/read data by per-command source tags.
module sockit_spi_arb
  import sockit_spi_pkg::*;
#(
  parameter int unsigned DW  = 32,
  parameter int unsigned DEP = 4,
  parameter logic        RR  = 1'b1
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          scw0_vld,
  output logic          scw0_rdy,
  input  cmd_t          scw0_dat,
  input  logic          scw1_vld,
  output logic          scw1_rdy,
  input  cmd_t          scw1_dat,
  output logic          scwo_vld,
  input  logic          scwo_rdy,
  output cmd_t          scwo_dat,
  input  logic          sdw0_vld,
  output logic          sdw0_rdy,
  input  logic [DW-1:0] sdw0_dat,
  input  logic          sdw1_vld,
  output logic          sdw1_rdy,
  input  logic [DW-1:0] sdw1_dat,
  output logic          sdwo_vld,
  input  logic          sdwo_rdy,
  output logic [DW-1:0] sdwo_dat,
  input  logic          sdri_vld,
  output logic          sdri_rdy,
  input  logic [DW-1:0] sdri_dat,
  output logic          sdr0_vld,
  input  logic          sdr0_rdy,
  output logic [DW-1:0] sdr0_dat,
  output logic          sdr1_vld,
  input  logic          sdr1_rdy,
  output logic [DW-1:0] sdr1_dat,
  output logic [1:0]    gnt,
  output logic          err,
  input  logic          err_clr
);

  arb_state_t state, state_nxt;
  arb_tag_t   last, last_nxt;
  arb_tag_t   tag, whead, rhead;
  cmd_t       cur;
  logic       cur_vld, stall;
  logic       wpush, wpop, wfull, wempty;
  logic       rpush, rpop, rfull, rempty;
  logic       spur;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Stall looks only at the registered full flag, so a read word popped this
  // cycle releases a stalled command one cycle later.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    tag       = 1'b0;
    cur       = '0;
    cur_vld   = 1'b0;
    stall     = 1'b0;
    gnt       = '0;
    scw0_rdy  = 1'b0;
    scw1_rdy  = 1'b0;
    scwo_vld  = 1'b0;
    scwo_dat  = '0;
    wpush     = 1'b0;
    rpush     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (scw0_vld || scw1_vld)
          state_nxt = arb_pick(RR, last, scw0_vld, scw1_vld) ? ARB_GNT1 : ARB_GNT0;
      end
      ARB_GNT0, ARB_GNT1: begin
        tag      = (state == ARB_GNT1);
        cur      = tag ? scw1_dat : scw0_dat;
        cur_vld  = tag ? scw1_vld : scw0_vld;
        stall    = (cur.wr && wfull) || (cur.rd && rfull);
        gnt      = tag ? 2'b10 : 2'b01;
        scwo_vld = cur_vld && !stall;
        scwo_dat = cur;
        scw0_rdy = !tag && scwo_rdy && !stall;
        scw1_rdy = tag && scwo_rdy && !stall;
        if (scwo_vld && scwo_rdy) begin
          wpush = cur.wr;
          rpush = cur.rd;
          if (cur.lst) begin
            state_nxt = ARB_IDLE;
            last_nxt  = tag;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    sdwo_vld = 1'b0;
    sdwo_dat = '0;
    sdw0_rdy = 1'b0;
    sdw1_rdy = 1'b0;
    if (!wempty) begin
      if (whead) begin
        sdwo_vld = sdw1_vld;
        sdwo_dat = sdw1_dat;
        sdw1_rdy = sdwo_rdy;
      end else begin
        sdwo_vld = sdw0_vld;
        sdwo_dat = sdw0_dat;
        sdw0_rdy = sdwo_rdy;
      end
    end
  end

  assign wpop = sdwo_vld && sdwo_rdy;

  // With no read tag queued every incoming word is accepted and dropped.
  always_comb begin
    sdr0_vld = 1'b0;
    sdr0_dat = '0;
    sdr1_vld = 1'b0;
    sdr1_dat = '0;
    sdri_rdy = 1'b0;
    if (rempty) begin
      sdri_rdy = sdri_vld;
    end else if (rhead) begin
      sdr1_vld = sdri_vld;
      sdr1_dat = sdri_dat;
      sdri_rdy = sdr1_rdy;
    end else begin
      sdr0_vld = sdri_vld;
      sdr0_dat = sdri_dat;
      sdri_rdy = sdr0_rdy;
    end
  end

  assign rpop = sdri_vld && sdri_rdy && !rempty;
  assign spur = sdri_vld && rempty;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)     err <= 1'b0;
    else if (spur)    err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  sockit_spi_arb_tfifo #(.DEP(DEP), .TW($bits(arb_tag_t))) u_wtag (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (wpush),
    .pop   (wpop),
    .din   (tag),
    .full  (wfull),
    .empty (wempty),
    .head  (whead)
  );

  sockit_spi_arb_tfifo #(.DEP(DEP), .TW($bits(arb_tag_t))) u_rtag (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (rpush),
    .pop   (rpop),
    .din   (tag),
    .full  (rfull),
    .empty (rempty),
    .head  (rhead)
  );

endmodule
